temp_sample_filter: RTL

- Upstream conditioning stage for the air-conditioning controller.
- Accepts raw 8-bit sensor readings in half-degree units and rejects fault codes.
- Produces a moving-average 5-bit temperature in whole degrees, saturated to 0..31. This output drives the controller's temperature input.
- Outputs a safe idle-band temperature while the average window is not yet full or the sensor is faulted.

---
 rtl/temp_sample_filter.sv | 109 ++++++++++
 1 files changed

// File: rtl/temp_sample_filter.sv
// Sensor conditioning ahead of the air-conditioning controller: rejects 8'hFF fault codes,
// averages N half-degree readings and reports a saturated whole-degree temperature.
module temp_sample_filter #(
   parameter int LOG2_N       = 2,
   parameter int FAULT_LIMIT  = 3,
   parameter int DEFAULT_TEMP = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_valid,
   input  logic [7:0] sample,
   output logic [4:0] temperature,
   output logic       temp_valid,
   output logic       fault
);

   localparam int N     = 1 << LOG2_N;
   localparam int SUM_W = 8 + LOG2_N;
   localparam logic [LOG2_N:0] FULL      = (LOG2_N+1)'(N);
   localparam logic [3:0]      FLIMIT    = 4'(FAULT_LIMIT);
   localparam logic [4:0]      DEF_TEMP  = 5'(DEFAULT_TEMP);
   localparam logic [7:0]      FAULT_CODE = 8'hFF;

   logic [7:0]        buf_q [N];
   logic [7:0]        buf_d [N];
   logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [LOG2_N:0]   fill_q, fill_d;
   logic [3:0]        fcnt_q, fcnt_d;
   logic              fault_q, fault_d;
   logic [4:0]        temp_q, temp_d;
   logic              tvld_q, tvld_d;
   logic              fault_declare;

   function automatic logic [4:0] sat_temp(input logic [SUM_W-1:0] s);
      logic [SUM_W-1:0] deg;
      deg = s >> (LOG2_N + 1);
      if (deg > SUM_W'(31)) return 5'd31;
      return deg[4:0];
   endfunction

   always_comb begin
      buf_d         = buf_q;
      wr_ptr_d      = wr_ptr_q;
      sum_d         = sum_q;
      fill_d        = fill_q;
      fcnt_d        = fcnt_q;
      fault_d       = fault_q;
      fault_declare = 1'b0;

      if (sample_valid) begin
         if (sample != FAULT_CODE) begin
            buf_d[wr_ptr_q] = sample;
            sum_d           = sum_q + SUM_W'(sample) - SUM_W'(buf_q[wr_ptr_q]);
            wr_ptr_d        = wr_ptr_q + 1'b1;
            fill_d          = (fill_q == FULL) ? FULL : fill_q + 1'b1;
            fcnt_d          = 4'd0;
            fault_d         = 1'b0;
         end else begin
            if (fcnt_q < FLIMIT) fcnt_d = fcnt_q + 4'd1;
            if (fcnt_d == FLIMIT) begin
               fault_declare = 1'b1;
               fault_d       = 1'b1;
               fill_d        = '0;
               sum_d         = '0;
               wr_ptr_d      = '0;
               for (int i = 0; i < N; i++) buf_d[i] = 8'd0;
            end
         end
      end

      // Output stage sees the window one edge after acceptance; valid is dropped on the
      // declaring edge itself so temp_valid and fault are never high together.
      if (fill_q == FULL) begin
         temp_d = sat_temp(sum_q);
         tvld_d = !fault_declare;
      end else begin
         temp_d = DEF_TEMP;
         tvld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) buf_q[i] <= 8'd0;
         wr_ptr_q <= '0;
         sum_q    <= '0;
         fill_q   <= '0;
         fcnt_q   <= '0;
         fault_q  <= 1'b0;
         temp_q   <= DEF_TEMP;
         tvld_q   <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         wr_ptr_q <= wr_ptr_d;
         sum_q    <= sum_d;
         fill_q   <= fill_d;
         fcnt_q   <= fcnt_d;
         fault_q  <= fault_d;
         temp_q   <= temp_d;
         tvld_q   <= tvld_d;
      end
   end

   assign temperature = temp_q;
   assign temp_valid  = tvld_q;
   assign fault       = fault_q;

endmodule
